// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared defaults and feeder state encoding for the conv_0 datapath
package conv_pkg;

    localparam int CONV_BIT_LEN  = 8;
    localparam int CONV_M_LEN    = 3;
    localparam int CONV_FEA_SIZE = 417;
    localparam int CONV_IMG_H    = 415;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WORK,
        PAUSE,
        FLUSH,
        DONE
    } feeder_state_e;

endpackage

// File: rtl/conv_line_buf.sv
// rtl/conv_line_buf.sv - one raw-row line buffer, async read and sync write at a shared address
module conv_line_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/conv_row_feeder.sv
// rtl/conv_row_feeder.sv - turns a raster pixel stream into three zero-padded, column-aligned rows for conv_0
module conv_row_feeder
    import conv_pkg::*;
#(
    parameter int BIT_LEN  = CONV_BIT_LEN,
    parameter int M_LEN    = CONV_M_LEN,
    parameter int FEA_SIZE = CONV_FEA_SIZE,
    parameter int IMG_H    = CONV_IMG_H
) (
    input  logic               i_Clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_valid,
    input  logic [BIT_LEN-1:0] i_pixel,
    output logic               o_ready,
    output logic               o_fStart,
    output logic               o_fStop,
    output logic               o_valid,
    output logic [BIT_LEN-1:0] o_dato0,
    output logic [BIT_LEN-1:0] o_dato1,
    output logic [BIT_LEN-1:0] o_dato2
);

    localparam int W  = FEA_SIZE - 2;
    localparam int XW = $clog2(FEA_SIZE);
    localparam int YW = $clog2(IMG_H);
    localparam int AW = $clog2(W);

    if (M_LEN != 3) begin : g_m_len_check
        $error("conv_row_feeder supports M_LEN == 3 only");
    end

    feeder_state_e      state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic               fstart_q, fstart_d;
    logic               fstop_q, fstop_d;
    logic               valid_q, valid_d;
    logic [BIT_LEN-1:0] dato0_q, dato0_d, dato1_q, dato1_d, dato2_q, dato2_d;

    logic               ready;
    logic               we_a, we_b;
    logic               is_pad, x_last;
    logic [AW-1:0]      lb_addr;
    logic [BIT_LEN-1:0] lb_a_rd, lb_b_rd;

    // Data column x maps to line-buffer entry x-1; padding columns never touch the buffers.
    assign lb_addr = AW'(x_q - XW'(1));
    assign is_pad  = (x_q == '0) || (x_q == XW'(FEA_SIZE - 1));
    assign x_last  = (x_q == XW'(FEA_SIZE - 1));

    conv_line_buf #(.DEPTH(W), .WIDTH(BIT_LEN), .AW(AW)) u_lb_a (
        .clk   (i_Clk),
        .we    (we_a),
        .addr  (lb_addr),
        .wdata (lb_b_rd),
        .rdata (lb_a_rd)
    );

    conv_line_buf #(.DEPTH(W), .WIDTH(BIT_LEN), .AW(AW)) u_lb_b (
        .clk   (i_Clk),
        .we    (we_b),
        .addr  (lb_addr),
        .wdata (i_pixel),
        .rdata (lb_b_rd)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        fstart_d = fstart_q;
        fstop_d  = 1'b0;
        valid_d  = 1'b0;
        dato0_d  = dato0_q;
        dato1_d  = dato1_q;
        dato2_d  = dato2_q;
        ready    = 1'b0;
        we_a     = 1'b0;
        we_b     = 1'b0;
        unique case (state_q)
            IDLE: begin
                fstart_d = 1'b0;
                if (i_start) begin
                    state_d = FILL;
                    x_d     = XW'(1);
                    y_d     = '0;
                end
            end
            FILL: begin
                fstart_d = 1'b0;
                ready    = 1'b1;
                if (i_valid) begin
                    we_b = 1'b1;
                    x_d  = x_q + XW'(1);
                    if (x_q == XW'(W)) begin
                        state_d = WORK;
                        x_d     = '0;
                    end
                end
            end
            WORK, PAUSE: begin
                fstart_d = 1'b1;
                if (is_pad) begin
                    valid_d = 1'b1;
                    dato0_d = '0;
                    dato1_d = '0;
                    dato2_d = '0;
                    x_d     = x_q + XW'(1);
                    if (x_last) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                        if (y_q == YW'(IMG_H - 2)) begin
                            state_d = FLUSH;
                        end
                    end
                end else begin
                    ready = 1'b1;
                    if (i_valid) begin
                        valid_d = 1'b1;
                        dato0_d = (y_q == '0) ? '0 : lb_a_rd;
                        dato1_d = lb_b_rd;
                        dato2_d = i_pixel;
                        we_a    = 1'b1;
                        we_b    = 1'b1;
                        x_d     = x_q + XW'(1);
                        state_d = WORK;
                    end else begin
                        state_d = PAUSE;
                    end
                end
            end
            FLUSH: begin
                fstart_d = 1'b1;
                valid_d  = 1'b1;
                dato0_d  = is_pad ? '0 : lb_a_rd;
                dato1_d  = is_pad ? '0 : lb_b_rd;
                dato2_d  = '0;
                x_d      = x_q + XW'(1);
                if (x_last) begin
                    state_d = DONE;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            DONE: begin
                fstart_d = 1'b0;
                fstop_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            fstart_q <= 1'b0;
            fstop_q  <= 1'b0;
            valid_q  <= 1'b0;
            dato0_q  <= '0;
            dato1_q  <= '0;
            dato2_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            fstart_q <= fstart_d;
            fstop_q  <= fstop_d;
            valid_q  <= valid_d;
            dato0_q  <= dato0_d;
            dato1_q  <= dato1_d;
            dato2_q  <= dato2_d;
        end
    end

    assign o_ready  = ready;
    assign o_fStart = fstart_q;
    assign o_fStop  = fstop_q;
    assign o_valid  = valid_q;
    assign o_dato0  = dato0_q;
    assign o_dato1  = dato1_q;
    assign o_dato2  = dato2_q;

endmodule

// File: tb/tb_conv_row_feeder.sv
// tb/tb_conv_row_feeder.sv - directed self-checking bench for conv_row_feeder on a 4x3 raw image
module tb_conv_row_feeder;

    localparam int FS   = 6;
    localparam int IH   = 3;
    localparam int W    = FS - 2;
    localparam int NCOL = FS * IH;
    localparam int NPIX = W * IH;

    logic       clk = 1'b0;
    logic       i_reset, i_start, i_valid;
    logic [7:0] i_pixel;
    logic       o_ready, o_fStart, o_fStop, o_valid;
    logic [7:0] o_dato0, o_dato1, o_dato2;

    int n_tests = 0;
    int n_fail  = 0;

    conv_row_feeder #(.BIT_LEN(8), .M_LEN(3), .FEA_SIZE(FS), .IMG_H(IH)) dut (
        .i_Clk    (clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_valid  (i_valid),
        .i_pixel  (i_pixel),
        .o_ready  (o_ready),
        .o_fStart (o_fStart),
        .o_fStop  (o_fStop),
        .o_valid  (o_valid),
        .o_dato0  (o_dato0),
        .o_dato1  (o_dato1),
        .o_dato2  (o_dato2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Raw pixel at row r, column x (1..W) is r*W + x, i.e. 1..12 in raster order.
    function automatic int exp_lane(input int lane, input int col);
        int row, x, r;
        row = col / FS;
        x   = col % FS;
        r   = row - 1 + lane;
        if (x == 0 || x == FS - 1 || r < 0 || r >= IH) return 0;
        return r * W + x;
    endfunction

    function automatic int exp_ready(input int col);
        int row, x;
        row = col / FS;
        x   = col % FS;
        return (row < IH - 1 && x >= 1 && x <= W) ? 1 : 0;
    endfunction

    task automatic run_frame(input string name, input int stall_idx, input int mid_start, input int exp_gap);
        int pix = 0, stall_cnt = 0, nval = 0, gap = 0;
        int last0 = 0, last1 = 0, last2 = 0;
        bit done = 0, acc, rdy, prev_valid = 0;
        i_start = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (pix < NPIX && !(pix == stall_idx && stall_cnt < 3)) begin
                i_valid = 1'b1;
                i_pixel = 8'(pix + 1);
            end else begin
                i_valid = 1'b0;
                if (pix == stall_idx && stall_cnt < 3) stall_cnt++;
            end
            if (cyc == mid_start) i_start = 1'b1;
            rdy = o_ready;
            acc = i_valid && o_ready;
            @(negedge clk);
            i_start = 1'b0;
            if (acc) pix++;
            if (o_valid) begin
                if (nval < NCOL) begin
                    chk($sformatf("%s d0 c%0d", name, nval), int'(o_dato0), exp_lane(0, nval));
                    chk($sformatf("%s d1 c%0d", name, nval), int'(o_dato1), exp_lane(1, nval));
                    chk($sformatf("%s d2 c%0d", name, nval), int'(o_dato2), exp_lane(2, nval));
                    chk($sformatf("%s ready c%0d", name, nval), int'(rdy), exp_ready(nval));
                    chk($sformatf("%s fstart c%0d", name, nval), int'(o_fStart), 1);
                end
                last0 = int'(o_dato0);
                last1 = int'(o_dato1);
                last2 = int'(o_dato2);
                nval++;
            end else if (nval > 0 && nval < NCOL) begin
                gap++;
                chk($sformatf("%s hold d0", name), int'(o_dato0), last0);
                chk($sformatf("%s hold d1", name), int'(o_dato1), last1);
                chk($sformatf("%s hold d2", name), int'(o_dato2), last2);
                chk($sformatf("%s hold fstart", name), int'(o_fStart), 1);
            end
            if (o_fStop) begin
                chk($sformatf("%s fstop_after_last", name), int'(prev_valid), 1);
                chk($sformatf("%s fstart_at_stop", name), int'(o_fStart), 0);
                done = 1;
            end
            prev_valid = o_valid;
        end
        i_valid = 1'b0;
        chk($sformatf("%s fstop_seen", name), int'(done), 1);
        chk($sformatf("%s columns", name), nval, NCOL);
        chk($sformatf("%s pixels", name), pix, NPIX);
        chk($sformatf("%s gap", name), gap, exp_gap);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, " ready"},  int'(o_ready),  0);
        chk({name, " fstart"}, int'(o_fStart), 0);
        chk({name, " fstop"},  int'(o_fStop),  0);
        chk({name, " valid"},  int'(o_valid),  0);
        chk({name, " d0"},     int'(o_dato0),  0);
        chk({name, " d1"},     int'(o_dato1),  0);
        chk({name, " d2"},     int'(o_dato2),  0);
    endtask

    initial begin
        int stops, valids;
        i_reset = 1'b1;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_pixel = '0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        i_reset = 1'b0;
        i_valid = 1'b1;
        i_pixel = 8'h55;
        repeat (3) begin
            @(negedge clk);
            chk("no_start ready", int'(o_ready), 0);
            chk("no_start valid", int'(o_valid), 0);
        end
        i_valid = 1'b0;

        run_frame("f1", -1, -1, 0);
        run_frame("b2b", -1, -1, 0);
        run_frame("stall", 6, 12, 3);

        // Abort a frame while it is emitting row 1.
        i_start = 1'b1;
        i_valid = 1'b1;
        for (int c = 0; c < 13; c++) begin
            i_pixel = 8'(8'hA0 + c);
            @(negedge clk);
            i_start = 1'b0;
        end
        chk("abort in_frame fstart", int'(o_fStart), 1);
        i_valid = 1'b0;
        i_reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("abort");
        i_reset = 1'b0;
        stops  = 0;
        valids = 0;
        repeat (8) begin
            @(negedge clk);
            stops  += int'(o_fStop);
            valids += int'(o_valid);
        end
        chk("abort fstop_count", stops, 0);
        chk("abort valid_count", valids, 0);

        run_frame("post_rst", -1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
